solution_cost_tracker: RTL and testbench
========================================

// Module: solution_cost_tracker
// PURPOSE
//  Consumes an AXI-stream of candidate GF(2) solution vectors (multi-beat packed) and keeps the cheapest one.
//  Cost is popcount or per-bit weighted sum.
//  Also reports solution count, tie count and protocol errors.
//  Sits between the solution enumerator stream and the day-10 output; generalised, mode-selectable form of cheapest-solution tracking.
// PARAMETERS
//  MAX_VEC_LEN     16  max solution vector length in bits (buttons)
//  AXI_DATA_WIDTH   8  stream beat width; vector spans ceil(vec_length/AXI_DATA_WIDTH) beats
//  WEIGHT_W         4  per-bit weight width (MODE_WEIGHTED)
//  COST_W           8  cost width; sums saturate at all-ones
//  COUNT_W         16  solution/tie counter width; counters saturate
// PORTS
//  clk            in   1                       clock; all logic on posedge
//  rst            in   1                       synchronous, active-high reset
//  start          in   1                       pulse: latch vec_length/mode/weights, begin a set
//  vec_length     in   $clog2(MAX_VEC_LEN+1)   valid bits per vector, sampled at start
//  mode           in   1                       0=MODE_POPCOUNT, 1=MODE_WEIGHTED, sampled at start
//  weights        in   MAX_VEC_LEN*WEIGHT_W    weight of bit i at [i*WEIGHT_W +: WEIGHT_W], sampled at start
//  s_tvalid       in   1                       stream beat valid
//  s_tready       out  1                       stream beat accept
//  s_tdata        in   AXI_DATA_WIDTH          beat k carries vector bits [k*W +: W], LSB-first
//  s_tlast        in   1                       set on final beat of final vector of the set
//  busy           out  1                       set in RECV/COST/UPDATE
//  done           out  1                       held high in DONE until accepted
//  accepted       in   1                       consumer ack of done; returns to IDLE
//  found          out  1                       at least one vector evaluated
//  min_cost       out  COST_W                  cost of best_vec
//  best_vec       out  MAX_VEC_LEN             cheapest vector; bits >= vec_length read 0
//  num_solutions  out  COUNT_W                 vectors evaluated
//  num_ties       out  COUNT_W                 vectors with cost == min_cost at evaluation, after the first
//  err            out  1                       tlast on non-final beat of a vector
// BEHAVIOUR
//  Reset: IDLE, s_tready=0, busy=0, done=0, found=0, err=0, min_cost=all-ones, best_vec=0, counters=0.
//  Reset mid-set: same values next cycle; a partial vector is discarded.
//  FSM IDLE -> RECV on start: latch config, clear found/err/counters/beat index, min_cost=all-ones, best_vec=0.
//  start outside IDLE is ignored.
//  FSM RECV: s_tready=1. On handshake, store beat at index b. Bits at or above vec_length are masked to 0.
//   Beats per vector = max(1, ceil(vec_length/W)); vec_length=0 gives 1 beat and cost 0.
//   Final beat of vector -> COST, latching last_vec=s_tlast.
//   Non-final beat with s_tlast=1 -> err=1, go to DONE, vector dropped.
//  FSM COST: s_tready=0. Register cost.
//   POPCOUNT: cost = number of set bits.
//   WEIGHTED: cost = sum of weights of set bits, saturating at 2^COST_W-1.
//  FSM UPDATE: s_tready=0. num_solutions++ (saturating).
//   If !found or cost < min_cost: take min_cost/best_vec, set found=1.
//   Else if cost == min_cost: num_ties++ (saturating); the first-seen vector is kept.
//   Next state: DONE if last_vec, else RECV with beat index cleared.
//  FSM DONE: done=1, outputs stable. On accepted -> IDLE. Outputs hold until the next start.
//  Latency: final beat handshake at cycle t -> COST t+1, UPDATE t+2, done=1 at t+3.
//   For a non-last vector, s_tready returns at t+3.
//  Throughput: one beat per cycle in RECV; 2 bubble cycles per vector.
// TESTING
//  POPCOUNT, vec_length=6, W=8: vectors 0x2D, 0x03 (tlast), 0x21 -> tlast handshake on 2nd vector, so set ends.
//   Expect min_cost=2, best_vec=0x03, num_solutions=2, num_ties=0, err=0.
//  POPCOUNT, vec_length=12, W=8: 2 beats/vector. 0xFFF then 0x801 (tlast on beat 2).
//   Expect min_cost=2, best_vec=0x801, done at t+3, s_tready=0 during COST/UPDATE.
//  WEIGHTED, weights bit0=9 bit1=1 bit2=1, vec_length=3: 0x1 then 0x6 (tlast).
//   Expect min_cost=2, best_vec=0x6. Ties: 0x6, 0x6 -> num_ties=1, first vector kept.
//  vec_length=12, W=8: tlast on beat 1 -> err=1, done=1, num_solutions=0, found=0.
//  Assert rst mid-vector, then new start -> clean set. Start while busy is ignored. Done holds until accepted.
//  Upper bits set in s_tdata above vec_length=5 -> ignored in cost and best_vec.
//   WEIGHTED all weights 15, COST_W=4 -> min_cost saturates at 15.

Source files
------------

// File: rtl/solution_cost_tracker.sv
// solution_cost_tracker: receives multi-beat GF(2) solution vectors over a
// stream and keeps the cheapest one (popcount or weighted cost).
module solution_cost_tracker #(
  parameter int MAX_VEC_LEN    = 16,
  parameter int AXI_DATA_WIDTH = 8,
  parameter int WEIGHT_W       = 4,
  parameter int COST_W         = 8,
  parameter int COUNT_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(MAX_VEC_LEN+1)-1:0] vec_length,
  input  logic                            mode,
  input  logic [MAX_VEC_LEN*WEIGHT_W-1:0] weights,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic [AXI_DATA_WIDTH-1:0]       s_tdata,
  input  logic                            s_tlast,
  output logic                            busy,
  output logic                            done,
  input  logic                            accepted,
  output logic                            found,
  output logic [COST_W-1:0]               min_cost,
  output logic [MAX_VEC_LEN-1:0]          best_vec,
  output logic [COUNT_W-1:0]              num_solutions,
  output logic [COUNT_W-1:0]              num_ties,
  output logic                            err
);

  localparam int LEN_W = $clog2(MAX_VEC_LEN+1);
  localparam int NB    = (MAX_VEC_LEN + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
  localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int VBUF  = NB * AXI_DATA_WIDTH;
  localparam int SUM_W = COST_W + WEIGHT_W + LEN_W;
  localparam logic [SUM_W-1:0] COST_SAT =
    {{(SUM_W-COST_W){1'b0}}, {COST_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_COST,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]                len_q;
  logic                            mode_q;
  logic [MAX_VEC_LEN*WEIGHT_W-1:0] weights_q;
  logic [BI_W-1:0]                 beat_q;
  logic [BI_W-1:0]                 last_beat_q;
  logic [BI_W-1:0]                 last_beat_d;
  logic                            last_q;
  logic [MAX_VEC_LEN-1:0]          vec_q;
  logic [MAX_VEC_LEN-1:0]          vec_d;
  logic [MAX_VEC_LEN-1:0]          len_mask;
  logic [VBUF-1:0]                 placed;
  logic [COST_W-1:0]               cost_q;
  logic [COST_W-1:0]               cost_d;
  logic [SUM_W-1:0]                sum;
  logic                            hs;
  logic                            final_beat;
  int                              nb_start;

  assign hs         = (state_q == S_RECV) && s_tvalid;
  assign final_beat = (beat_q == last_beat_q);
  assign s_tready   = (state_q == S_RECV);
  assign busy       = (state_q == S_RECV) || (state_q == S_COST) ||
                      (state_q == S_UPDATE);
  assign done       = (state_q == S_DONE);

  // a zero-length vector still occupies one beat
  always_comb begin
    nb_start = (int'(vec_length) + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
    if (nb_start > NB) nb_start = NB;
    if (nb_start < 1) nb_start = 1;
    last_beat_d = BI_W'(nb_start - 1);
  end

  always_comb begin
    for (int i = 0; i < MAX_VEC_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    placed = VBUF'(s_tdata) << (int'(beat_q) * AXI_DATA_WIDTH);
    vec_d  = ((beat_q == '0) ? '0 : vec_q) |
             (placed[MAX_VEC_LEN-1:0] & len_mask);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < MAX_VEC_LEN; i++) begin
      if (vec_q[i]) begin
        sum = sum + (mode_q ? SUM_W'(weights_q[i*WEIGHT_W +: WEIGHT_W])
                            : SUM_W'(1));
      end
    end
    cost_d = (sum > COST_SAT) ? '1 : sum[COST_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_RECV;
      S_RECV: begin
        if (hs) begin
          if (final_beat)   state_d = S_COST;
          else if (s_tlast) state_d = S_DONE;
        end
      end
      S_COST:   state_d = S_UPDATE;
      S_UPDATE: state_d = last_q ? S_DONE : S_RECV;
      S_DONE:   if (accepted) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      mode_q        <= 1'b0;
      weights_q     <= '0;
      beat_q        <= '0;
      last_beat_q   <= '0;
      last_q        <= 1'b0;
      vec_q         <= '0;
      cost_q        <= '0;
      found         <= 1'b0;
      err           <= 1'b0;
      min_cost      <= '1;
      best_vec      <= '0;
      num_solutions <= '0;
      num_ties      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q         <= vec_length;
            mode_q        <= mode;
            weights_q     <= weights;
            last_beat_q   <= last_beat_d;
            beat_q        <= '0;
            last_q        <= 1'b0;
            found         <= 1'b0;
            err           <= 1'b0;
            min_cost      <= '1;
            best_vec      <= '0;
            num_solutions <= '0;
            num_ties      <= '0;
          end
        end
        S_RECV: begin
          if (hs) begin
            vec_q <= vec_d;
            if (final_beat)   last_q <= s_tlast;
            else if (s_tlast) err    <= 1'b1;
            else              beat_q <= beat_q + BI_W'(1);
          end
        end
        S_COST: cost_q <= cost_d;
        S_UPDATE: begin
          beat_q <= '0;
          if (num_solutions != '1) num_solutions <= num_solutions + 1'b1;
          if (!found || cost_q < min_cost) begin
            found    <= 1'b1;
            min_cost <= cost_q;
            best_vec <= vec_q;
          end else if (cost_q == min_cost) begin
            if (num_ties != '1) num_ties <= num_ties + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_solution_cost_tracker.sv
// tb_solution_cost_tracker: directed and random sets checked against a
// cost/min reference model built from plain arithmetic.
module tb_solution_cost_tracker;

  localparam int ML = 16;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  vec_length;
  logic        mode;
  logic [63:0] weights;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic        s_tlast;
  logic        busy;
  logic        done;
  logic        accepted;
  logic        found;
  logic [3:0]  min_cost;
  logic [15:0] best_vec;
  logic [15:0] num_solutions;
  logic [15:0] num_ties;
  logic        err;

  always #5 clk = ~clk;

  solution_cost_tracker #(
    .MAX_VEC_LEN(ML), .AXI_DATA_WIDTH(W), .WEIGHT_W(4),
    .COST_W(CW), .COUNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_length(vec_length),
    .mode(mode), .weights(weights), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .busy(busy), .done(done), .accepted(accepted), .found(found),
    .min_cost(min_cost), .best_vec(best_vec),
    .num_solutions(num_solutions), .num_ties(num_ties), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // configuration and stimulus for the next set
  bit          cfg_mode;
  int          cfg_len;
  logic [63:0] cfg_w;
  logic [15:0] vq[$];
  bit          err_flag;
  bit          mid_start;

  // reference model
  bit          m_found;
  int          m_min;
  logic [15:0] m_best;
  int          m_num;
  int          m_ties;
  bit          m_err;

  function automatic logic [15:0] lmask(input int len);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (i < len);
    return m;
  endfunction

  function automatic int cost_of(input logic [15:0] v);
    int s = 0;
    for (int i = 0; i < cfg_len; i++)
      if (v[i]) s += cfg_mode ? int'(cfg_w[i*4 +: 4]) : 1;
    return (s > CMAX) ? CMAX : s;
  endfunction

  task automatic model_eval(input logic [15:0] v);
    int c;
    c = cost_of(v);
    m_num++;
    if (!m_found || c < m_min) begin
      m_found = 1;
      m_min   = c;
      m_best  = v;
    end else if (c == m_min) begin
      m_ties++;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_tready"}, 32'(s_tready), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_found"}, 32'(found), 0);
    chk({pfx, "_err"}, 32'(err), 0);
    chk({pfx, "_min"}, 32'(min_cost), CMAX);
    chk({pfx, "_best"}, 32'(best_vec), 0);
    chk({pfx, "_nsol"}, 32'(num_solutions), 0);
    chk({pfx, "_ties"}, 32'(num_ties), 0);
  endtask

  task automatic do_start();
    vec_length = 5'(cfg_len);
    mode       = cfg_mode;
    weights    = cfg_w;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_found = 0; m_min = CMAX; m_best = '0;
    m_num = 0; m_ties = 0; m_err = 0;
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic wait_hs();
    int guard = 0;
    while (!s_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_tready) chk("hs_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic run_set();
    int          nb;
    bit          stop;
    logic [15:0] v;
    logic [15:0] wirev;
    logic [15:0] mk;
    int          guard;
    mk = lmask(cfg_len);
    nb = (cfg_len == 0) ? 1 : (cfg_len + W - 1) / W;
    stop = 0;
    do_start();
    for (int vi = 0; vi < vq.size() && !stop; vi++) begin
      bit is_last;
      is_last = (vi == vq.size() - 1);
      v = vq[vi] & mk;
      wirev = v | (16'($urandom) & ~mk);
      for (int k = 0; k < nb && !stop; k++) begin
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 2)) @(negedge clk);
        s_tdata  = wirev[k*8 +: 8];
        s_tlast  = (is_last && k == nb - 1) || (is_last && err_flag && k == 0);
        s_tvalid = 1'b1;
        wait_hs();
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (is_last && err_flag && k == 0 && nb > 1) begin
          chk("err_done_now", 32'(done), 1);
          m_err = 1;
          stop  = 1;
        end else if (k == nb - 1) begin
          chk("cost_tready", 32'(s_tready), 0);
          if (mid_start) begin
            vec_length = 5'd3;
            mode       = ~cfg_mode;
            weights    = '0;
            start      = 1'b1;
          end
          @(negedge clk);
          start = 1'b0;
          chk("upd_tready", 32'(s_tready), 0);
          chk("upd_done", 32'(done), 0);
          model_eval(v);
          @(negedge clk);
          if (is_last) chk("lat_done", 32'(done), 1);
          else         chk("lat_tready", 32'(s_tready), 1);
        end
      end
    end
    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("set_done", 32'(done), 1);
    chk("found", 32'(found), 32'(m_found));
    chk("min_cost", 32'(min_cost), 32'(m_min));
    chk("best_vec", 32'(best_vec), 32'(m_best));
    chk("num_sol", 32'(num_solutions), 32'(m_num));
    chk("num_ties", 32'(num_ties), 32'(m_ties));
    chk("err", 32'(err), 32'(m_err));
    chk("done_busy", 32'(busy), 0);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    chk("done_hold", 32'(done), 1);
    accepted = 1'b1;
    @(negedge clk);
    accepted = 1'b0;
    chk("acc_done", 32'(done), 0);
    chk("acc_busy", 32'(busy), 0);
    chk("acc_min_hold", 32'(min_cost), 32'(m_min));
    chk("acc_best_hold", 32'(best_vec), 32'(m_best));
  endtask

  initial begin
    rst = 1'b1; start = 0; vec_length = 0; mode = 0; weights = 0;
    s_tvalid = 0; s_tdata = 0; s_tlast = 0; accepted = 0;
    err_flag = 0; mid_start = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    cfg_mode = 0; cfg_len = 6; cfg_w = '0;
    vq = '{16'h2D, 16'h03};
    run_set();

    cfg_len = 12; mid_start = 1;
    vq = '{16'hFFF, 16'h801};
    run_set();
    mid_start = 0;

    cfg_mode = 1; cfg_len = 3; cfg_w = 64'h119;
    vq = '{16'h1, 16'h6};
    run_set();
    vq = '{16'h6, 16'h6};
    run_set();

    cfg_mode = 0; cfg_len = 12; err_flag = 1;
    vq = '{16'hABC};
    run_set();
    err_flag = 0;

    cfg_len = 12;
    do_start();
    s_tdata = 8'h5A; s_tvalid = 1'b1; s_tlast = 1'b0;
    wait_hs();
    @(negedge clk);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    @(negedge clk);
    vq = '{16'h0F0, 16'h300};
    run_set();

    cfg_mode = 0; cfg_len = 5;
    vq = '{16'hFFE3, 16'hFF11};
    run_set();

    cfg_mode = 1; cfg_len = 16; cfg_w = '1;
    vq = '{16'hFFFF, 16'h0003};
    run_set();

    cfg_len = 0;
    vq = '{16'hFFFF};
    run_set();

    for (int s = 0; s < 40; s++) begin
      int nv;
      int nb;
      cfg_mode  = 1'($urandom_range(0, 1));
      cfg_len   = $urandom_range(0, 16);
      cfg_w     = {$urandom, $urandom};
      mid_start = ($urandom_range(0, 3) == 0);
      nb        = (cfg_len == 0) ? 1 : (cfg_len + W - 1) / W;
      err_flag  = (nb > 1) && ($urandom_range(0, 5) == 0);
      nv        = $urandom_range(1, 5);
      vq.delete();
      for (int i = 0; i < nv; i++) begin
        if (i > 0 && $urandom_range(0, 2) == 0) vq.push_back(vq[i-1]);
        else vq.push_back(16'($urandom));
      end
      run_set();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
